// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared constants for the memory-access stage.
//   ES_TO_MS_BUS_WD / MS_TO_WS_BUS_WD : pipeline bus widths.
//   LD_* : bit positions of the one-hot load_op field.
package mem_stage_pkg;
  localparam int ES_TO_MS_BUS_WD = 113;
  localparam int MS_TO_WS_BUS_WD = 107;

  localparam int LD_W  = 0;
  localparam int LD_B  = 1;
  localparam int LD_H  = 2;
  localparam int LD_BU = 3;
  localparam int LD_HU = 4;
endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: picks the addressed byte/halfword out of a 32-bit read word
// and sign- or zero-extends it according to the one-hot load_op.
// Ports:
//   load_op   in  5   one-hot load kind (all zero: not a load)
//   addr      in  2   low address bits, select the byte lane
//   rdata     in  32  raw read word
//   load_data out 32  aligned, extended result
module load_align
  import mem_stage_pkg::*;
(
  input  logic [4:0]  load_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    // ld.w and non-loads see the word unchanged.
    load_data = rdata;
    if (load_op[LD_B])
      load_data = {{24{byte_sel[7]}}, byte_sel};
    else if (load_op[LD_BU])
      load_data = {24'd0, byte_sel};
    else if (load_op[LD_H])
      load_data = {{16{half_sel[15]}}, half_sel};
    else if (load_op[LD_HU])
      load_data = {16'd0, half_sel};
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and write-back.
// Latches the execute bus, aligns/extends synchronous SRAM load data, and
// keeps that data in a one-entry hold buffer while write-back stalls (the
// SRAM only presents read data for one cycle).
// Ports:
//   clk, reset (sync, active-high)
//   ws_allowin / ms_allowin            : handshake with write-back / execute
//   es_to_ms_valid, es_to_ms_bus       : incoming instruction
//   data_sram_rdata                    : load data, one cycle after request
//   wb_flush                           : kill contents (exception / ertn)
//   ms_to_ws_valid, ms_to_ws_bus       : outgoing instruction
//   ms_to_ds_dest/result/load_op/is_exc: hazard and forwarding info to decode
//   ms_pc                              : PC of the latched instruction
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       wb_flush,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [4:0]                 ms_to_ds_dest,
  output logic [31:0]                ms_to_ds_result,
  output logic                       ms_to_ds_load_op,
  output logic                       ms_to_ds_is_exc,
  output logic [31:0]                ms_pc
);
  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_r;

  logic [4:0]  ms_load_op;
  logic        ms_res_from_mem;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_alu_result;
  logic        ms_res_from_csr;
  logic [31:0] ms_csr_rdata;
  logic        ms_is_exc;
  logic        ms_need_cnt_l;
  logic        ms_need_cnt_h;
  logic        ms_need_cnt_id;

  logic        buf_valid;
  logic [31:0] rdata_buf;
  logic [31:0] rdata_src;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign {ms_load_op, ms_res_from_mem, ms_gr_we, ms_dest, ms_alu_result,
          ms_pc, ms_res_from_csr, ms_csr_rdata, ms_is_exc,
          ms_need_cnt_l, ms_need_cnt_h, ms_need_cnt_id} = es_to_ms_bus_r;

  assign ms_allowin     = !ms_valid || ws_allowin;
  assign ms_to_ws_valid = ms_valid;

  always_ff @(posedge clk) begin
    if (reset)
      ms_valid <= 1'b0;
    else if (wb_flush)
      ms_valid <= 1'b0;
    else if (ms_allowin)
      ms_valid <= es_to_ms_valid;
  end

  // Bus contents are don't-care while invalid, so no reset here.
  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin)
      es_to_ms_bus_r <= es_to_ms_bus;
  end

  // Clearing whenever the stage drains guarantees every new instruction
  // starts with an empty buffer and reads the live SRAM data.
  always_ff @(posedge clk) begin
    if (reset || wb_flush || (ms_valid && ws_allowin))
      buf_valid <= 1'b0;
    else if (ms_valid && ms_res_from_mem && !buf_valid && !ws_allowin)
      buf_valid <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (ms_valid && ms_res_from_mem && !buf_valid && !ws_allowin)
      rdata_buf <= data_sram_rdata;
  end

  assign rdata_src = buf_valid ? rdata_buf : data_sram_rdata;

  load_align u_load_align (
    .load_op   (ms_load_op),
    .addr      (ms_alu_result[1:0]),
    .rdata     (rdata_src),
    .load_data (load_data)
  );

  assign final_result = ms_res_from_mem ? load_data : ms_alu_result;

  assign ms_to_ws_bus = {ms_gr_we, ms_dest, final_result, ms_pc,
                         ms_res_from_csr, ms_csr_rdata, ms_is_exc,
                         ms_need_cnt_l, ms_need_cnt_h, ms_need_cnt_id};

  assign ms_to_ds_dest    = ms_valid ? ms_dest : 5'd0;
  assign ms_to_ds_result  = ms_res_from_csr ? ms_csr_rdata : final_result;
  assign ms_to_ds_load_op = (|ms_load_op) & ms_valid;
  assign ms_to_ds_is_exc  = ms_is_exc & ms_valid;
endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [112:0] es_to_ms_bus;
  logic [31:0]  data_sram_rdata;
  logic         wb_flush;
  logic         ms_to_ws_valid;
  logic [106:0] ms_to_ws_bus;
  logic [4:0]   ms_to_ds_dest;
  logic [31:0]  ms_to_ds_result;
  logic         ms_to_ds_load_op;
  logic         ms_to_ds_is_exc;
  logic [31:0]  ms_pc;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .ws_allowin       (ws_allowin),
    .ms_allowin       (ms_allowin),
    .es_to_ms_valid   (es_to_ms_valid),
    .es_to_ms_bus     (es_to_ms_bus),
    .data_sram_rdata  (data_sram_rdata),
    .wb_flush         (wb_flush),
    .ms_to_ws_valid   (ms_to_ws_valid),
    .ms_to_ws_bus     (ms_to_ws_bus),
    .ms_to_ds_dest    (ms_to_ds_dest),
    .ms_to_ds_result  (ms_to_ds_result),
    .ms_to_ds_load_op (ms_to_ds_load_op),
    .ms_to_ds_is_exc  (ms_to_ds_is_exc),
    .ms_pc            (ms_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [112:0] mk_es(input logic [4:0] lop, input logic rfm,
      input logic gwe, input logic [4:0] dest, input logic [31:0] alu,
      input logic [31:0] pc, input logic rfc, input logic [31:0] csr,
      input logic exc);
    return {lop, rfm, gwe, dest, alu, pc, rfc, csr, exc, 3'b101};
  endfunction

  function automatic logic [106:0] mk_ws(input logic gwe, input logic [4:0] dest,
      input logic [31:0] fin, input logic [31:0] pc, input logic rfc,
      input logic [31:0] csr, input logic exc);
    return {gwe, dest, fin, pc, rfc, csr, exc, 3'b101};
  endfunction

  task automatic chk(input string tag, input logic [106:0] obs, input logic [106:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Put one instruction into the stage (takes one clock edge).
  task automatic issue(input logic [112:0] bus);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = bus;
    tick();
    es_to_ms_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0; data_sram_rdata = '0; wb_flush = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_allowin",  107'(ms_allowin), 107'(1));
    chk("rst_valid",    107'(ms_to_ws_valid), 107'(0));
    chk("rst_dest",     107'(ms_to_ds_dest), 107'(0));
    chk("rst_load_op",  107'(ms_to_ds_load_op), 107'(0));
    chk("rst_is_exc",   107'(ms_to_ds_is_exc), 107'(0));

    // ld.b at addr 2
    issue(mk_es(5'b00010, 1, 1, 5'd3, 32'h1000_0002, 32'h1c00_0000, 0, 32'h0, 0));
    data_sram_rdata = 32'h1284_5678; #1;
    chk("ldb_valid",  107'(ms_to_ws_valid), 107'(1));
    chk("ldb_bus",    ms_to_ws_bus, mk_ws(1, 5'd3, 32'hFFFF_FF84, 32'h1c00_0000, 0, 32'h0, 0));
    chk("ldb_fwd",    107'(ms_to_ds_result), 107'(32'hFFFF_FF84));
    chk("ldb_dest",   107'(ms_to_ds_dest), 107'(3));
    chk("ldb_ldop",   107'(ms_to_ds_load_op), 107'(1));
    chk("ldb_pc",     107'(ms_pc), 107'(32'h1c00_0000));

    // ld.bu, same inputs
    issue(mk_es(5'b01000, 1, 1, 5'd4, 32'h1000_0002, 32'h1c00_0004, 0, 32'h0, 0));
    data_sram_rdata = 32'h1284_5678; #1;
    chk("ldbu_fwd",   107'(ms_to_ds_result), 107'(32'h0000_0084));

    // ld.h at addr 2
    issue(mk_es(5'b00100, 1, 1, 5'd5, 32'h1000_0002, 32'h1c00_0008, 0, 32'h0, 0));
    data_sram_rdata = 32'h8001_7FFF; #1;
    chk("ldh_bus",    ms_to_ws_bus, mk_ws(1, 5'd5, 32'hFFFF_8001, 32'h1c00_0008, 0, 32'h0, 0));

    // ld.hu at addr 0
    issue(mk_es(5'b10000, 1, 1, 5'd6, 32'h1000_0000, 32'h1c00_000c, 0, 32'h0, 0));
    data_sram_rdata = 32'h8001_7FFF; #1;
    chk("ldhu_fwd",   107'(ms_to_ds_result), 107'(32'h0000_7FFF));

    // ld.w with three stalled cycles
    issue(mk_es(5'b00001, 1, 1, 5'd7, 32'h2000_0000, 32'h1c00_0010, 0, 32'h0, 0));
    ws_allowin = 1'b0; data_sram_rdata = 32'hDEAD_BEEF; #1;
    chk("stall0_res",   107'(ms_to_ds_result), 107'(32'hDEAD_BEEF));
    chk("stall0_allow", 107'(ms_allowin), 107'(0));
    tick();
    data_sram_rdata = 32'h1111_1111; #1;
    chk("stall1_buf",   107'(dut.buf_valid), 107'(1));
    chk("stall1_res",   107'(ms_to_ds_result), 107'(32'hDEAD_BEEF));
    chk("stall1_allow", 107'(ms_allowin), 107'(0));
    tick();
    data_sram_rdata = 32'h2222_2222; #1;
    chk("stall2_bus",   ms_to_ws_bus, mk_ws(1, 5'd7, 32'hDEAD_BEEF, 32'h1c00_0010, 0, 32'h0, 0));
    chk("stall2_valid", 107'(ms_to_ws_valid), 107'(1));
    ws_allowin = 1'b1; #1;
    chk("release_res",   107'(ms_to_ds_result), 107'(32'hDEAD_BEEF));
    chk("release_allow", 107'(ms_allowin), 107'(1));
    tick();
    chk("drained_valid", 107'(ms_to_ws_valid), 107'(0));
    chk("drained_buf",   107'(dut.buf_valid), 107'(0));
    chk("drained_dest",  107'(ms_to_ds_dest), 107'(0));

    // back-to-back add then ld.w
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_es(5'b00000, 0, 1, 5'd9, 32'h0000_1234, 32'h1c00_0020, 0, 32'h0, 0);
    tick();
    es_to_ms_bus = mk_es(5'b00001, 1, 1, 5'd10, 32'h2000_0004, 32'h1c00_0024, 0, 32'h0, 0);
    #1;
    chk("b2b_add_dest", 107'(ms_to_ds_dest), 107'(9));
    chk("b2b_add_ldop", 107'(ms_to_ds_load_op), 107'(0));
    chk("b2b_add_res",  107'(ms_to_ds_result), 107'(32'h0000_1234));
    tick();
    es_to_ms_valid = 1'b0;
    data_sram_rdata = 32'hCAFE_F00D; #1;
    chk("b2b_ld_dest",  107'(ms_to_ds_dest), 107'(10));
    chk("b2b_ld_ldop",  107'(ms_to_ds_load_op), 107'(1));
    chk("b2b_ld_res",   107'(ms_to_ds_result), 107'(32'hCAFE_F00D));
    tick();
    chk("b2b_end_valid", 107'(ms_to_ws_valid), 107'(0));

    // csr result with exception flag
    issue(mk_es(5'b00000, 0, 1, 5'd12, 32'h0000_0055, 32'h1c00_0030, 1, 32'hABCD_0001, 1));
    chk("csr_fwd",  107'(ms_to_ds_result), 107'(32'hABCD_0001));
    chk("csr_exc",  107'(ms_to_ds_is_exc), 107'(1));
    chk("csr_bus",  ms_to_ws_bus, mk_ws(1, 5'd12, 32'h0000_0055, 32'h1c00_0030, 1, 32'hABCD_0001, 1));

    // flush against a buffered load and an incoming instruction
    issue(mk_es(5'b00001, 1, 1, 5'd13, 32'h2000_0008, 32'h1c00_0040, 0, 32'h0, 0));
    ws_allowin = 1'b0; data_sram_rdata = 32'h5555_AAAA;
    tick();
    chk("flush_pre_buf", 107'(dut.buf_valid), 107'(1));
    ws_allowin = 1'b1; wb_flush = 1'b1; es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_es(5'b00000, 0, 1, 5'd14, 32'h0, 32'h1c00_0044, 0, 32'h0, 0);
    tick();
    wb_flush = 1'b0; es_to_ms_valid = 1'b0; #1;
    chk("flush_valid", 107'(ms_to_ws_valid), 107'(0));
    chk("flush_dest",  107'(ms_to_ds_dest), 107'(0));
    chk("flush_buf",   107'(dut.buf_valid), 107'(0));

    // reset during a buffered stalled load
    issue(mk_es(5'b00001, 1, 1, 5'd15, 32'h2000_000c, 32'h1c00_0050, 0, 32'h0, 0));
    ws_allowin = 1'b0; data_sram_rdata = 32'h7777_8888;
    tick();
    chk("rst2_pre_buf", 107'(dut.buf_valid), 107'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    chk("rst2_valid", 107'(dut.ms_valid), 107'(0));
    chk("rst2_buf",   107'(dut.buf_valid), 107'(0));
    chk("rst2_allow", 107'(ms_allowin), 107'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
